// File: rtl/rgb_pwm_driver.sv
// Three-channel active-low PWM stage with double-buffered duties committed on period wrap.
// Latency: capture to visible output 1..PWM_INTERVAL cycles; duty_ready low while an update is pending.
module rgb_pwm_driver #(
  parameter int unsigned PWM_INTERVAL = 1000,
  parameter int unsigned DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] red_duty,
  input  logic [DW-1:0] green_duty,
  input  logic [DW-1:0] blue_duty,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          red_n,
  output logic          green_n,
  output logic          blue_n,
  output logic          period_start
);

  localparam logic [DW-1:0] POS_LAST = DW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL);

  logic [DW-1:0] pos_q, pos_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] red_pend_q, red_pend_d;
  logic [DW-1:0] green_pend_q, green_pend_d;
  logic [DW-1:0] blue_pend_q, blue_pend_d;
  logic [DW-1:0] red_active_q, red_active_d;
  logic [DW-1:0] green_active_q, green_active_d;
  logic [DW-1:0] blue_active_q, blue_active_d;
  logic          red_n_q, red_n_d;
  logic          green_n_q, green_n_d;
  logic          blue_n_q, blue_n_d;
  logic          period_start_q, period_start_d;

  logic wrap;
  logic capture;

  function automatic logic [DW-1:0] sat(input logic [DW-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  assign wrap    = (pos_q == POS_LAST);
  assign capture = duty_valid && !pending_q;

  always_comb begin
    pos_d          = wrap ? '0 : pos_q + DW'(1);
    pending_d      = pending_q;
    red_pend_d     = red_pend_q;
    green_pend_d   = green_pend_q;
    blue_pend_d    = blue_pend_q;
    red_active_d   = red_active_q;
    green_active_d = green_active_q;
    blue_active_d  = blue_active_q;

    // Commit uses the pre-edge pending flag, so a capture on the wrap edge waits a full period.
    if (wrap && pending_q) begin
      red_active_d   = red_pend_q;
      green_active_d = green_pend_q;
      blue_active_d  = blue_pend_q;
      pending_d      = 1'b0;
    end

    if (capture) begin
      red_pend_d   = sat(red_duty);
      green_pend_d = sat(green_duty);
      blue_pend_d  = sat(blue_duty);
      pending_d    = 1'b1;
    end

    red_n_d        = !(pos_d < red_active_d);
    green_n_d      = !(pos_d < green_active_d);
    blue_n_d       = !(pos_d < blue_active_d);
    period_start_d = (pos_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q          <= POS_LAST;
      pending_q      <= 1'b0;
      red_pend_q     <= '0;
      green_pend_q   <= '0;
      blue_pend_q    <= '0;
      red_active_q   <= '0;
      green_active_q <= '0;
      blue_active_q  <= '0;
      red_n_q        <= 1'b1;
      green_n_q      <= 1'b1;
      blue_n_q       <= 1'b1;
      period_start_q <= 1'b0;
    end else begin
      pos_q          <= pos_d;
      pending_q      <= pending_d;
      red_pend_q     <= red_pend_d;
      green_pend_q   <= green_pend_d;
      blue_pend_q    <= blue_pend_d;
      red_active_q   <= red_active_d;
      green_active_q <= green_active_d;
      blue_active_q  <= blue_active_d;
      red_n_q        <= red_n_d;
      green_n_q      <= green_n_d;
      blue_n_q       <= blue_n_d;
      period_start_q <= period_start_d;
    end
  end

  assign duty_ready   = !pending_q;
  assign red_n        = red_n_q;
  assign green_n      = green_n_q;
  assign blue_n       = blue_n_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PWM_INTERVAL=10; all checks sampled on the falling edge.
module tb_rgb_pwm_driver;
  localparam int N  = 10;
  localparam int DW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] red_duty, green_duty, blue_duty;
  logic          duty_valid;
  logic          duty_ready;
  logic          red_n, green_n, blue_n;
  logic          period_start;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_pwm_driver #(.PWM_INTERVAL(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .red_n(red_n), .green_n(green_n), .blue_n(blue_n),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance at least one cycle, find the next position-0 cycle, then step p positions.
  task automatic next_pos(input int p);
    bit found;
    found = 0;
    @(negedge clk);
    for (int i = 0; i < 2 * N + 2; i++) begin
      if (period_start === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL next_pos_timeout: period_start not seen, required within %0d cycles", 2 * N + 2);
    end
    for (int i = 0; i < p; i++) @(negedge clk);
  endtask

  // Called in a position-0 cycle; checks positions 0..N-1, returns in position N-1.
  task automatic check_period(input int r, input int g, input int b, input string name);
    logic er, eg, eb, ep;
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      er = !(k < r); eg = !(k < g); eb = !(k < b); ep = (k == 0);
      n_tests++;
      if ({red_n, green_n, blue_n, period_start} !== {er, eg, eb, ep}) begin
        n_fail++;
        $display("FAIL %s pos%0d: rgb_n/ps got %b%b%b/%b required %b%b%b/%b",
                 name, k, red_n, green_n, blue_n, period_start, er, eg, eb, ep);
      end
    end
  endtask

  task automatic drive(input int r, input int g, input int b, input logic v);
    red_duty = DW'(r); green_duty = DW'(g); blue_duty = DW'(b); duty_valid = v;
  endtask

  task automatic test_reset;
    logic ep;
    drive(0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({red_n, green_n, blue_n, period_start, duty_ready} !== 5'b11101) begin
      n_fail++;
      $display("FAIL reset_hold: rgb_n/ps/rdy got %b%b%b/%b/%b required 111/0/1",
               red_n, green_n, blue_n, period_start, duty_ready);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      ep = (c == 1 || c == 11 || c == 21);
      n_tests++;
      if ({red_n, green_n, blue_n, period_start, duty_ready} !== {3'b111, ep, 1'b1}) begin
        n_fail++;
        $display("FAIL idle cycle%0d: rgb_n/ps/rdy got %b%b%b/%b/%b required 111/%b/1",
                 c, red_n, green_n, blue_n, period_start, duty_ready, ep);
      end
    end
  endtask

  task automatic test_basic_duty;
    next_pos(5);
    drive(3, 7, 0, 1'b1);
    for (int k = 6; k < N; k++) begin
      @(negedge clk);
      duty_valid = 1'b0;
      n_tests++;
      if (duty_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_ready_low pos%0d: got %b required 0", k, duty_ready);
      end
    end
    @(negedge clk);
    n_tests++;
    if (duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_back: got %b required 1", duty_ready);
    end
    check_period(3, 7, 0, "basic");
  endtask

  task automatic test_extremes;
    next_pos(2);
    drive(10, 15, 0, 1'b1);
    @(negedge clk);
    duty_valid = 1'b0;
    next_pos(0);
    n_tests++;
    if (dut.green_active_q !== DW'(10)) begin
      n_fail++;
      $display("FAIL green_saturate: got %0d required 10", dut.green_active_q);
    end
    check_period(10, 10, 0, "extremes");
  endtask

  task automatic test_wrap_capture;
    next_pos(9);
    drive(4, 0, 0, 1'b1);
    @(negedge clk);
    duty_valid = 1'b0;
    n_tests++;
    if (duty_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_captured: ready got %b required 0", duty_ready);
    end
    check_period(10, 10, 0, "wrap_old");
    @(negedge clk);
    check_period(4, 0, 0, "wrap_new");
  endtask

  task automatic test_backpressure;
    next_pos(3);
    drive(2, 0, 0, 1'b1);
    @(negedge clk);
    red_duty = DW'(6);
    n_tests++;
    if (duty_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_low: got %b required 0", duty_ready);
    end
    next_pos(0);
    n_tests++;
    if ({duty_ready, red_n} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_pos0: ready/red_n got %b/%b required 1/0", duty_ready, red_n);
    end
    @(negedge clk);
    duty_valid = 1'b0;
    n_tests++;
    if (duty_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_capture: ready got %b required 0", duty_ready);
    end
    for (int k = 1; k < N; k++) begin
      if (k > 1) @(negedge clk);
      n_tests++;
      if (red_n !== !(k < 2)) begin
        n_fail++;
        $display("FAIL bp_first pos%0d: red_n got %b required %b", k, red_n, !(k < 2));
      end
    end
    @(negedge clk);
    check_period(6, 0, 0, "bp_second");
  endtask

  task automatic test_mid_reset;
    next_pos(2);
    drive(8, 0, 0, 1'b1);
    @(negedge clk);
    duty_valid = 1'b0;
    next_pos(3);
    drive(5, 0, 0, 1'b1);
    @(negedge clk);
    duty_valid = 1'b0;
    n_tests++;
    if ({red_n, duty_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL mr_before: red_n/ready got %b/%b required 0/0", red_n, duty_ready);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({red_n, green_n, blue_n, period_start, duty_ready} !== 5'b11101) begin
      n_fail++;
      $display("FAIL mr_async: rgb_n/ps/rdy got %b%b%b/%b/%b required 111/0/1",
               red_n, green_n, blue_n, period_start, duty_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red_n, green_n, blue_n, duty_ready} !== 4'b1111) begin
        n_fail++;
        $display("FAIL mr_dark cycle%0d: rgb_n/rdy got %b%b%b/%b required 111/1",
                 c, red_n, green_n, blue_n, duty_ready);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0);
    test_reset();
    test_basic_duty();
    test_extremes();
    test_wrap_capture();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Three-channel PWM output stage sitting directly downstream of the RGB fade sequencer. Accepts per-colour duty values through a valid/ready handshake and double-buffers them so changes land only on period boundaries. Drives the active-low RGB LED pins, and emits a one-cycle period-start strobe the sequencer can pace its steps from.

## Interface
- PWM_INTERVAL, 1000: period length in clock cycles; legal range ≥ 2.
- DW, $clog2(PWM_INTERVAL+1): duty width (derived; 10 for the default).

Ports:
- clk  in  1  system clock; all flops rise-edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- red_duty  in  DW  requested red on-time, in cycles per period.
- green_duty  in  DW  requested green on-time.
- blue_duty  in  DW  requested blue on-time.
- duty_valid  in  1  the three duty inputs form a valid update.
- duty_ready  out  1  an update can be accepted; equals !pending.
- red_n  out  1  red LED pin, active-low; 0 = lit.
- green_n  out  1  green LED pin, active-low.
- blue_n  out  1  blue LED pin, active-low.
- period_start  out  1  high for exactly the cycle at period position 0.

## Operation
- Period counter `pos` runs 0..PWM_INTERVAL-1 and wraps to 0. It advances every cycle.
- Reset (async, rst_n=0) sets:
  - pos = PWM_INTERVAL-1
  - active duties = 0
  - pending = 0, so duty_ready = 1
  - red_n = green_n = blue_n = 1
  - period_start = 0
- Capture: on an edge with duty_valid && duty_ready:
  - Each duty is saturated to min(duty, PWM_INTERVAL).
  - The saturated values are stored in the pending registers, and pending is set to 1.
  - duty_valid while duty_ready=0 is ignored. It is not queued, and the sender must hold it.
- Commit: on every edge where pos wraps PWM_INTERVAL-1 → 0:
  - If pending was 1 before the edge, active ← pending registers and pending ← 0.
  - A capture on that same wrap edge is not committed at that edge. It commits at the following wrap.
  - Capture and commit on the same edge cannot conflict, because capture requires pending=0.
- Output law, for every cycle at position k:
  - red_n = !(k < red_active), where red_active is the active duty for the current period. Green and blue follow the same rule.
  - Duty 0 means the LED is dark for the whole period.
  - Duty PWM_INTERVAL means the LED is lit for the whole period.
  - Duty d gives exactly d lit cycles, at positions 0..d-1.
- Outputs are flops computed from next-state pos and active values. They are glitch-free and change only on clk edges.
- period_start is a flop; it is 1 exactly in the cycles where pos = 0.

## Timing
- First rising edge after rst_n deasserts: pos enters 0, period_start=1, and outputs follow the law with active = 0 (all dark).
- Capture to ready: duty_ready drops in the cycle after the capture edge.
- Capture to output: new duties become visible at the first position-0 cycle after capture. The latency is 1..PWM_INTERVAL cycles.
- Ready recovery: duty_ready rises in the position-0 cycle in which the commit took effect. A new capture is therefore possible at the edge ending position 0.
- Steady state: a sender that pulses valid whenever ready=1 gets exactly one update per period.
- Reset asserted mid-period: all outputs go to their reset values immediately (asynchronously), and any pending update is discarded.
- Values > PWM_INTERVAL are never stored; saturation is applied at capture.

## Test plan
Benches use PWM_INTERVAL=10.
- **Reset/idle:** hold rst_n=0 for 3 cycles, then release and run 25 cycles.
  - red_n/green_n/blue_n = 1 throughout.
  - period_start is high in cycles 1, 11 and 21 after release.
  - duty_ready = 1 throughout.
- **Basic duty:** capture r=3, g=7, b=0 in position 5. Check the next period:
  - red_n is 0 for positions 0-2.
  - green_n is 0 for positions 0-6.
  - blue_n stays 1.
  - duty_ready is 0 from position 6 through position 9, and 1 again at position 0.
- **Extremes and saturation:** capture r=10, g=15, b=0.
  - Next period: red_n and green_n are 0 for all 10 cycles; blue_n stays 1.
  - Internally, green_active reads 10.
- **Wrap-edge capture:** assert valid with r=4 on the edge ending position 9.
  - The following period still uses the old duty.
  - r=4 appears one period later.
- **Backpressure:** hold valid with r=2, then change to r=6 while ready=0.
  - Only r=2 is captured.
  - r=6 is accepted after ready returns, and shows in the period after that.
- **Mid-period reset:** with r=8 active, assert rst_n=0 at position 4.
  - red_n goes to 1 immediately, and pending is cleared.
  - After release, the LED stays dark until a new capture commits.
